// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity encodings, receiver FSM states
// and a constant-width helper used to size counters and pointers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_t;

    function automatic int uart_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead FIFO: rdata presents the head entry whenever the FIFO is non-empty,
// and reads as zero when empty. Push while full is accepted only alongside a pop.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = uart_clog2(DEPTH),
    localparam int CW = uart_clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // DEPTH is a power of two, so pointers wrap naturally at AW bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width, parity, stop bits) with start-bit glitch
// rejection, sticky error flags and a show-ahead receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                                CLK,
    input  logic                                RST_X,
    input  logic                                RXD,
    input  logic                                RD_EN,
    output logic [7:0]                          RD_DATA,
    output logic                                RD_VALID,
    output logic [uart_clog2(FIFO_DEPTH+1)-1:0] FIFO_COUNT,
    output logic                                FRAME_ERR,
    output logic                                PARITY_ERR,
    output logic                                OVERRUN,
    input  logic                                CLR_ERR
);

    localparam int CNT_W = uart_clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       PAR_IS_ODD = (PARITY == PAR_ODD);

    logic                 rxd_p0;
    logic                 rxd_p1;
    logic                 rxs;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 done_q, done_d;
    logic                 frame_set;
    logic                 tick;
    logic                 push_req;
    logic                 pop_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    // Two-flop synchroniser, idles high so reset never looks like a start edge
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= RXD;
            rxd_p1 <= rxd_p0;
        end
    end

    assign rxs  = rxd_p1;
    assign tick = (cnt_q == LAST_CNT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        done_d     = 1'b0;
        frame_set  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rxs) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (!rxs) begin
                        state_d    = RX_DATA;
                        par_bad_d  = 1'b0;
                        stop_bad_d = 1'b0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_PAR: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = RX_STOP;
                    if ((^shreg_q ^ rxs) != PAR_IS_ODD) par_bad_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        stop_bad_d = 1'b1;
                        frame_set  = 1'b1;
                    end
                    // Leave mid-bit so the next start edge is caught with margin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = RX_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge CLK) begin
        shreg_q <= shreg_d;
    end

    // Frame completion: one cycle after the last stop sample
    assign push_req = done_q && !par_bad_q && !stop_bad_q;
    assign pop_req  = RD_EN && !fifo_empty;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            FRAME_ERR  <= 1'b0;
            PARITY_ERR <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            if (frame_set)              FRAME_ERR  <= 1'b1;
            else if (CLR_ERR)           FRAME_ERR  <= 1'b0;
            if (done_q && par_bad_q)    PARITY_ERR <= 1'b1;
            else if (CLR_ERR)           PARITY_ERR <= 1'b0;
            if (push_req && fifo_full && !pop_req) OVERRUN <= 1'b1;
            else if (CLR_ERR)           OVERRUN    <= 1'b0;
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_X),
        .push  (push_req),
        .pop   (RD_EN),
        .wdata (shreg_q),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (FIFO_COUNT)
    );

    assign RD_DATA  = 8'(fifo_rdata);
    assign RD_VALID = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 instance and a 7E2 instance driven
// with directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_fifo;

    localparam int CPB    [2] = '{16, 8};
    localparam int DBITS  [2] = '{8, 7};
    localparam int PARM   [2] = '{0, 2};
    localparam int STOPS  [2] = '{1, 2};
    localparam int DEPTH  [2] = '{16, 4};

    logic       clk;
    logic       rst_x;
    logic       rxd      [2];
    logic       rd_en    [2];
    logic       clr      [2];
    logic [7:0] rd_data  [2];
    logic       rd_valid [2];
    logic       fe       [2];
    logic       pe       [2];
    logic       ov       [2];
    logic [4:0] cnt0;
    logic [2:0] cnt1;

    int checks   = 0;
    int failures = 0;
    bit drain    = 1'b1;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit m_fe [2];
    bit m_pe [2];
    bit m_ov [2];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(DBITS[0]), .PARITY(PARM[0]),
                   .STOP_BITS(STOPS[0]), .FIFO_DEPTH(DEPTH[0])) u_dut0 (
        .CLK(clk), .RST_X(rst_x), .RXD(rxd[0]), .RD_EN(rd_en[0]),
        .RD_DATA(rd_data[0]), .RD_VALID(rd_valid[0]), .FIFO_COUNT(cnt0),
        .FRAME_ERR(fe[0]), .PARITY_ERR(pe[0]), .OVERRUN(ov[0]), .CLR_ERR(clr[0])
    );

    uart_rx_fifo #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(DBITS[1]), .PARITY(PARM[1]),
                   .STOP_BITS(STOPS[1]), .FIFO_DEPTH(DEPTH[1])) u_dut1 (
        .CLK(clk), .RST_X(rst_x), .RXD(rxd[1]), .RD_EN(rd_en[1]),
        .RD_DATA(rd_data[1]), .RD_VALID(rd_valid[1]), .FIFO_COUNT(cnt1),
        .FRAME_ERR(fe[1]), .PARITY_ERR(pe[1]), .OVERRUN(ov[1]), .CLR_ERR(clr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void q_push(input int d, input logic [7:0] v);
        if (d == 0) q0.push_back(v);
        else q1.push_back(v);
    endfunction

    function automatic logic [7:0] q_pop(input int d);
        return (d == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic int get_cnt(input int d);
        return (d == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    // Monitor: drains each FIFO as soon as it shows data and scores the byte
    initial begin
        rd_en[0] = 1'b0;
        rd_en[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (drain) begin
                for (int d = 0; d < 2; d++) begin
                    rd_en[d] = 1'b0;
                    if (rst_x && rd_valid[d]) begin
                        if (q_size(d) == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_byte%0d actual=0x%0h required=none", d, rd_data[d]);
                        end else begin
                            chk($sformatf("rd_data%0d", d), rd_data[d], q_pop(d));
                        end
                        rd_en[d] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic drive_bit(input int d, input logic b);
        rxd[d] = b;
        repeat (CPB[d]) @(negedge clk);
    endtask

    // Frame-level model decides the outcome up front, then the line is driven
    task automatic send(input int d, input logic [7:0] data, input bit bad_par, input bit bad_stop);
        logic [7:0] v;
        logic       pbit;
        bit         par_fail;
        v        = data & 8'((1 << DBITS[d]) - 1);
        pbit     = (PARM[d] == 1) ? ~(^v) : (^v);
        par_fail = (PARM[d] != 0) && bad_par;
        if (par_fail) pbit = ~pbit;
        if (par_fail) m_pe[d] = 1'b1;
        if (bad_stop) m_fe[d] = 1'b1;
        if (!par_fail && !bad_stop) begin
            if (q_size(d) >= DEPTH[d]) m_ov[d] = 1'b1;
            else q_push(d, v);
        end
        drive_bit(d, 1'b0);
        for (int i = 0; i < DBITS[d]; i++) drive_bit(d, v[i]);
        if (PARM[d] != 0) drive_bit(d, pbit);
        for (int i = 0; i < STOPS[d]; i++) drive_bit(d, !(bad_stop && i == 0));
        rxd[d] = 1'b1;
        repeat (2 * CPB[d]) @(negedge clk);
    endtask

    task automatic check_state(input int d, input string tag);
        chk($sformatf("%s_frame_err%0d", tag, d), fe[d], m_fe[d]);
        chk($sformatf("%s_parity_err%0d", tag, d), pe[d], m_pe[d]);
        chk($sformatf("%s_overrun%0d", tag, d), ov[d], m_ov[d]);
        chk($sformatf("%s_count%0d", tag, d), get_cnt(d), q_size(d));
    endtask

    task automatic clear(input int d);
        clr[d] = 1'b1;
        @(negedge clk);
        clr[d] = 1'b0;
        m_fe[d] = 1'b0;
        m_pe[d] = 1'b0;
        m_ov[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input int d);
        int t;
        t = 0;
        while ((q_size(d) != 0 || rd_valid[d]) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("drain_in_time%0d", d), int'(t < 2000), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_rd_valid%0d", tag, d), rd_valid[d], 0);
            chk($sformatf("%s_rd_data%0d", tag, d), rd_data[d], 0);
            check_state(d, tag);
        end
    endtask

    initial begin
        #(1000000);
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rnd;
        int         d;
        int         glen;
        rst_x  = 1'b0;
        rxd[0] = 1'b1;
        rxd[1] = 1'b1;
        clr[0] = 1'b0;
        clr[1] = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_state("reset");
        rst_x = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame held in the FIFO, then popped by hand
        drain = 1'b0;
        send(0, 8'hA5, 1'b0, 1'b0);
        chk("t1_valid", rd_valid[0], 1);
        chk("t1_data", rd_data[0], 8'hA5);
        check_state(0, "t1");
        rd_en[0] = 1'b1;
        @(negedge clk);
        rd_en[0] = 1'b0;
        void'(q_pop(0));
        chk("t1_valid_after_pop", rd_valid[0], 0);
        check_state(0, "t1_pop");
        drain = 1'b1;

        // Short low pulse is rejected as a glitch
        rxd[0] = 1'b0;
        repeat (4) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (3 * CPB[0]) @(negedge clk);
        chk("t2_valid", rd_valid[0], 0);
        check_state(0, "t2_glitch");
        send(0, 8'h3C, 1'b0, 1'b0);
        check_state(0, "t2");

        // Framing error, clear, recovery
        send(0, 8'h55, 1'b0, 1'b1);
        check_state(0, "t3_bad");
        clear(0);
        check_state(0, "t3_clr");
        send(0, 8'h0F, 1'b0, 1'b0);
        check_state(0, "t3");

        // Parity error on the even-parity instance, then good resend
        send(1, 8'h07, 1'b1, 1'b0);
        check_state(1, "t4_bad");
        send(1, 8'h07, 1'b0, 1'b0);
        check_state(1, "t4");
        clear(1);

        // Random frames, errors and glitches on both instances
        for (int i = 0; i < 24; i++) begin
            d   = $urandom_range(0, 1);
            rnd = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                glen = $urandom_range(1, CPB[d] / 2 - 1);
                rxd[d] = 1'b0;
                repeat (glen) @(negedge clk);
                rxd[d] = 1'b1;
                repeat (2 * CPB[d]) @(negedge clk);
            end
            send(d, rnd, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            check_state(d, "rnd");
            if ($urandom_range(0, 2) == 0) begin
                clear(d);
                check_state(d, "rnd_clr");
            end
        end
        wait_drain(0);
        wait_drain(1);
        clear(0);
        clear(1);

        // Fill past capacity without reading
        drain = 1'b0;
        for (int i = 0; i < 17; i++) send(0, 8'(i), 1'b0, 1'b0);
        chk("t5_count", get_cnt(0), 16);
        chk("t5_overrun", ov[0], 1);
        chk("t5_head", rd_data[0], 8'h00);
        check_state(0, "t5_full");
        drain = 1'b1;
        wait_drain(0);
        check_state(0, "t5_drained");
        clear(0);

        // Reset in the middle of a 0xFF frame discards it
        rxd[0] = 1'b0;
        repeat (CPB[0]) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (4 * CPB[0] + CPB[0] / 2) @(negedge clk);
        rst_x = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            m_fe[k] = 1'b0;
            m_pe[k] = 1'b0;
            m_ov[k] = 1'b0;
        end
        rst_x = 1'b1;
        @(negedge clk);
        check_reset_state("t6_reset");
        repeat (6 * CPB[0]) @(negedge clk);
        send(0, 8'h81, 1'b0, 1'b0);
        wait_drain(0);
        check_state(0, "t6");

        chk("end_queue0", q_size(0), 0);
        chk("end_queue1", q_size(1), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
